// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: micro-op kinds, branch funct3
// encodings and the packed result record held for the CDB.
package bru_pkg;

    localparam int unsigned BRU_DATA_WIDTH = 32;
    localparam int unsigned BRU_TAG_WIDTH  = 6;

    typedef enum logic [1:0] {
        BRU_BRANCH = 2'd0,
        BRU_JAL    = 2'd1,
        BRU_JALR   = 2'd2,
        BRU_RSVD   = 2'd3
    } bru_kind_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } bru_funct3_e;

    typedef struct packed {
        logic [BRU_TAG_WIDTH-1:0]  tag;
        logic                      taken;
        logic                      mispredict;
        logic [BRU_DATA_WIDTH-1:0] next_pc;
        logic [BRU_DATA_WIDTH-1:0] link;
    } bru_result_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/result bundle between the branch reservation station, the resolve
// unit and the CDB arbiter. res_exc_o exists only with BRU_MISALIGN_CHECK_EN.
interface branch_resolve_unit_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 6
) ();
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [1:0]            req_kind_i;
    logic [2:0]            req_funct3_i;
    logic [DATA_WIDTH-1:0] req_op1_i;
    logic [DATA_WIDTH-1:0] req_op2_i;
    logic [DATA_WIDTH-1:0] req_pc_i;
    logic [DATA_WIDTH-1:0] req_imm_i;
    logic                  req_pred_taken_i;
    logic [DATA_WIDTH-1:0] req_pred_target_i;
    logic [TAG_WIDTH-1:0]  req_tag_i;
    logic                  flush_i;
    logic                  res_valid_o;
    logic                  res_ready_i;
    logic [TAG_WIDTH-1:0]  res_tag_o;
    logic                  res_taken_o;
    logic                  res_mispredict_o;
    logic [DATA_WIDTH-1:0] res_next_pc_o;
    logic [DATA_WIDTH-1:0] res_link_o;
    logic                  redirect_valid_o;
    logic [DATA_WIDTH-1:0] redirect_pc_o;
`ifdef BRU_MISALIGN_CHECK_EN
    logic                  res_exc_o;
`endif

    modport master (
        output req_valid_i, req_kind_i, req_funct3_i, req_op1_i, req_op2_i,
               req_pc_i, req_imm_i, req_pred_taken_i, req_pred_target_i,
               req_tag_i, flush_i, res_ready_i,
        input  req_ready_o, res_valid_o, res_tag_o, res_taken_o,
               res_mispredict_o, res_next_pc_o, res_link_o,
`ifdef BRU_MISALIGN_CHECK_EN
               res_exc_o,
`endif
               redirect_valid_o, redirect_pc_o
    );

    modport slave (
        input  req_valid_i, req_kind_i, req_funct3_i, req_op1_i, req_op2_i,
               req_pc_i, req_imm_i, req_pred_taken_i, req_pred_target_i,
               req_tag_i, flush_i, res_ready_i,
        output req_ready_o, res_valid_o, res_tag_o, res_taken_o,
               res_mispredict_o, res_next_pc_o, res_link_o,
`ifdef BRU_MISALIGN_CHECK_EN
               res_exc_o,
`endif
               redirect_valid_o, redirect_pc_o
    );
endinterface

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational RV32I branch condition evaluator (EQ/NE, signed and
// unsigned less-than and their complements).
module bru_cond_eval
    import bru_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [2:0]            funct3,
    output logic                  taken_cond
);
    logic eq;
    logic lt_s;
    logic lt_u;

    always_comb begin
        eq   = (op1 == op2);
        lt_u = (op1 < op2);
        // Differing signs: op1 is smaller exactly when it is the negative one.
        if (op1[DATA_WIDTH-1] != op2[DATA_WIDTH-1]) begin
            lt_s = op1[DATA_WIDTH-1];
        end else begin
            lt_s = (op1[DATA_WIDTH-2:0] < op2[DATA_WIDTH-2:0]);
        end
    end

    always_comb begin
        taken_cond = 1'b0;
        case (funct3)
            F3_BEQ:  taken_cond = eq;
            F3_BNE:  taken_cond = !eq;
            F3_BLT:  taken_cond = lt_s;
            F3_BGE:  taken_cond = !lt_s;
            F3_BLTU: taken_cond = lt_u;
            F3_BGEU: taken_cond = !lt_u;
            default: taken_cond = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// Execution-stage branch resolver: registered result with CDB handshake and a
// one-shot misprediction redirect. Optional BRU_MISALIGN_CHECK_EN adds res_exc_o.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    branch_resolve_unit_if.slave bus
);
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] br_target;
    logic [DATA_WIDTH-1:0] jalr_sum;
    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] next_pc;
    logic [TAG_WIDTH-1:0]  tag_d;
    logic                  cond_taken;
    logic                  taken;
    logic                  mispredict;
    logic                  accept;
    logic                  res_valid_q;
    logic                  fresh_q;
    bru_kind_e             kind;
    bru_result_t           res_d;
    bru_result_t           res_q;
`ifdef BRU_MISALIGN_CHECK_EN
    logic                  exc_d;
    logic                  exc_q;
`endif

    bru_cond_eval #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cond_eval (
        .op1        (bus.req_op1_i),
        .op2        (bus.req_op2_i),
        .funct3     (bus.req_funct3_i),
        .taken_cond (cond_taken)
    );

    assign kind   = bru_kind_e'(bus.req_kind_i);
    assign tag_d  = bus.req_tag_i;
    assign accept = bus.req_valid_i && bus.req_ready_o;

    always_comb begin
        pc_plus4  = bus.req_pc_i + DATA_WIDTH'(4);
        br_target = bus.req_pc_i + bus.req_imm_i;
        jalr_sum  = bus.req_op1_i + bus.req_imm_i;
        case (kind)
            BRU_JAL: begin
                taken  = 1'b1;
                target = br_target;
            end
            BRU_JALR: begin
                taken  = 1'b1;
                target = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
            end
            default: begin
                taken  = cond_taken;
                target = br_target;
            end
        endcase
        next_pc    = taken ? target : pc_plus4;
        mispredict = (taken != bus.req_pred_taken_i) ||
                     (taken && (target != bus.req_pred_target_i));
`ifdef BRU_MISALIGN_CHECK_EN
        // A misaligned target traps via the ROB instead of redirecting.
        exc_d = taken && next_pc[1];
        if (exc_d) begin
            mispredict = 1'b0;
        end
`endif
        res_d            = '0;
        res_d.tag        = tag_d;
        res_d.taken      = taken;
        res_d.mispredict = mispredict;
        res_d.next_pc    = next_pc;
        res_d.link       = pc_plus4;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_q       <= '0;
            res_valid_q <= 1'b0;
            fresh_q     <= 1'b0;
`ifdef BRU_MISALIGN_CHECK_EN
            exc_q       <= 1'b0;
`endif
        end else if (bus.flush_i) begin
            res_valid_q <= 1'b0;
            fresh_q     <= 1'b0;
        end else if (accept) begin
            res_q       <= res_d;
            res_valid_q <= 1'b1;
            fresh_q     <= 1'b1;
`ifdef BRU_MISALIGN_CHECK_EN
            exc_q       <= exc_d;
`endif
        end else begin
            fresh_q <= 1'b0;
            if (bus.res_ready_i) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready_o      = !res_valid_q || bus.res_ready_i;
    assign bus.res_valid_o      = res_valid_q;
    assign bus.res_tag_o        = res_q.tag;
    assign bus.res_taken_o      = res_q.taken;
    assign bus.res_mispredict_o = res_q.mispredict;
    assign bus.res_next_pc_o    = res_q.next_pc;
    assign bus.res_link_o       = res_q.link;
    assign bus.redirect_valid_o = res_valid_q && fresh_q && res_q.mispredict;
    assign bus.redirect_pc_o    = res_q.next_pc;
`ifdef BRU_MISALIGN_CHECK_EN
    assign bus.res_exc_o        = exc_q;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus
// randomized traffic against a behavioural model of the resolver.
module tb_branch_resolve_unit;
    import bru_pkg::*;

    typedef struct {
        logic [5:0]  tag;
        logic        taken;
        logic        mis;
        logic [31:0] npc;
        logic [31:0] link;
        logic        exc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   redirect_cnt;

    exp_t er;
    logic ev;
    logic efresh;

    branch_resolve_unit_if #(.DATA_WIDTH(32), .TAG_WIDTH(6)) bus ();

    branch_resolve_unit #(
        .DATA_WIDTH (32),
        .TAG_WIDTH  (6)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] kind, input logic [2:0] f3,
                                   input logic [31:0] op1, input logic [31:0] op2,
                                   input logic [31:0] pc, input logic [31:0] imm,
                                   input logic pt, input logic [31:0] ptgt,
                                   input logic [5:0] tag);
        exp_t r;
        logic [31:0] tgt;
        r.tag = tag;
        if (kind == 2'd1 || kind == 2'd2) begin
            r.taken = 1'b1;
        end else begin
            case (f3)
                3'd0:    r.taken = (op1 == op2);
                3'd1:    r.taken = (op1 != op2);
                3'd4:    r.taken = ($signed(op1) <  $signed(op2));
                3'd5:    r.taken = ($signed(op1) >= $signed(op2));
                3'd6:    r.taken = (op1 <  op2);
                3'd7:    r.taken = (op1 >= op2);
                default: r.taken = 1'b0;
            endcase
        end
        tgt    = (kind == 2'd2) ? ((op1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        r.npc  = r.taken ? tgt : pc + 32'd4;
        r.link = pc + 32'd4;
        r.mis  = (r.taken != pt) || (r.taken && tgt != ptgt);
        r.exc  = 1'b0;
`ifdef BRU_MISALIGN_CHECK_EN
        r.exc = r.taken && r.npc[1];
        if (r.exc) r.mis = 1'b0;
`endif
        return r;
    endfunction

    task automatic send(input logic [1:0] kind, input logic [2:0] f3,
                        input logic [31:0] op1, input logic [31:0] op2,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptgt, input logic [5:0] tag);
        bus.req_valid_i       = 1'b1;
        bus.req_kind_i        = kind;
        bus.req_funct3_i      = f3;
        bus.req_op1_i         = op1;
        bus.req_op2_i         = op2;
        bus.req_pc_i          = pc;
        bus.req_imm_i         = imm;
        bus.req_pred_taken_i  = pt;
        bus.req_pred_target_i = ptgt;
        bus.req_tag_i         = tag;
    endtask

    // One clock: check outputs mid-cycle, advance the model, step past the edge.
    task automatic step();
        logic exp_ready;
        @(negedge clk);
        exp_ready = !ev || bus.res_ready_i;
        check_eq("req_ready", bus.req_ready_o, exp_ready);
        check_eq("res_valid", bus.res_valid_o, ev);
        check_eq("redirect_valid", bus.redirect_valid_o, ev && efresh && er.mis);
        check_eq("res_tag", bus.res_tag_o, er.tag);
        check_eq("res_taken", bus.res_taken_o, er.taken);
        check_eq("res_mispredict", bus.res_mispredict_o, er.mis);
        check_eq("res_next_pc", bus.res_next_pc_o, er.npc);
        check_eq("res_link", bus.res_link_o, er.link);
        check_eq("redirect_pc", bus.redirect_pc_o, er.npc);
`ifdef BRU_MISALIGN_CHECK_EN
        check_eq("res_exc", bus.res_exc_o, er.exc);
`endif
        if (bus.redirect_valid_o) redirect_cnt++;
        if (bus.flush_i) begin
            ev     = 1'b0;
            efresh = 1'b0;
        end else if (bus.req_valid_i && exp_ready) begin
            er = model(bus.req_kind_i, bus.req_funct3_i, bus.req_op1_i, bus.req_op2_i,
                       bus.req_pc_i, bus.req_imm_i, bus.req_pred_taken_i,
                       bus.req_pred_target_i, bus.req_tag_i);
            ev     = 1'b1;
            efresh = 1'b1;
        end else begin
            efresh = 1'b0;
            if (bus.res_ready_i) ev = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  k;
        logic [31:0] a, b, pc, imm, tg;
        total = 0;
        bad = 0;
        redirect_cnt = 0;
        er = '{tag: '0, taken: 1'b0, mis: 1'b0, npc: '0, link: '0, exc: 1'b0};
        ev = 1'b0;
        efresh = 1'b0;
        rst_n = 1'b0;
        bus.flush_i = 1'b0;
        bus.res_ready_i = 1'b0;
        send(2'd0, 3'd0, '0, '0, '0, '0, 1'b0, '0, '0);
        bus.req_valid_i = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_res_valid", bus.res_valid_o, 1'b0);
        check_eq("rst_redirect", bus.redirect_valid_o, 1'b0);
        check_eq("rst_ready", bus.req_ready_o, 1'b1);
        check_eq("rst_next_pc", bus.res_next_pc_o, 32'h0);
        check_eq("rst_tag", bus.res_tag_o, 6'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // BLT with a negative op1: taken and mispredicted.
        bus.res_ready_i = 1'b1;
        send(2'd0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0, 6'd1);
        step();
        bus.req_valid_i = 1'b0;
        check_eq("blt_taken", bus.res_taken_o, 1'b1);
        check_eq("blt_mis", bus.res_mispredict_o, 1'b1);
        check_eq("blt_npc", bus.res_next_pc_o, 32'h120);
        check_eq("blt_redirect", bus.redirect_valid_o, 1'b1);
        check_eq("blt_redirect_pc", bus.redirect_pc_o, 32'h120);
        step();

        // BLTU with the same operands: not taken.
        send(2'd0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0, 6'd2);
        step();
        bus.req_valid_i = 1'b0;
        check_eq("bltu_taken", bus.res_taken_o, 1'b0);
        check_eq("bltu_npc", bus.res_next_pc_o, 32'h104);
        check_eq("bltu_redirect", bus.redirect_valid_o, 1'b0);
        step();

        // JALR clears bit 0 of the sum.
        send(2'd2, 3'd0, 32'h2003, 32'h0, 32'h400, 32'h0, 1'b1, 32'h2002, 6'd3);
        step();
        bus.req_valid_i = 1'b0;
        check_eq("jalr_npc", bus.res_next_pc_o, 32'h2002);
        check_eq("jalr_link", bus.res_link_o, 32'h404);
        check_eq("jalr_mis", bus.res_mispredict_o, 1'b0);
        step();

        // Mispredicting BEQ held through a 3-cycle CDB stall with a waiting op.
        bus.res_ready_i = 1'b0;
        send(2'd0, 3'd0, 32'd5, 32'd5, 32'h800, 32'h40, 1'b0, 32'h0, 6'd4);
        step();
        redirect_cnt = 0;
        send(2'd0, 3'd1, 32'd1, 32'd2, 32'h900, 32'h8, 1'b1, 32'h908, 6'd5);
        repeat (3) begin
            check_eq("stall_ready", bus.req_ready_o, 1'b0);
            step();
        end
        check_eq("stall_npc", bus.res_next_pc_o, 32'h840);
        bus.res_ready_i = 1'b1;
        step();
        bus.req_valid_i = 1'b0;
        check_eq("stall_redirect_cnt", redirect_cnt, 1);
        check_eq("stall_next_tag", bus.res_tag_o, 6'd5);
        step();

        // Back-to-back BNE with continuous grant.
        for (int i = 0; i < 4; i++) begin
            send(2'd0, 3'd1, i, 32'd7, 32'h1000 + 32'(i * 4), 32'h10, 1'b0, 32'h0, 6'(10 + i));
            step();
            check_eq("b2b_valid", bus.res_valid_o, 1'b1);
            check_eq("b2b_tag", bus.res_tag_o, 6'(10 + i));
        end
        bus.req_valid_i = 1'b0;
        step();

        // Flush while holding a result and offering a new request.
        bus.res_ready_i = 1'b0;
        send(2'd1, 3'd0, '0, '0, 32'h2000, 32'h100, 1'b1, 32'h2100, 6'd20);
        step();
        send(2'd1, 3'd0, '0, '0, 32'h3000, 32'h100, 1'b0, 32'h0, 6'd21);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        bus.req_valid_i = 1'b0;
        check_eq("flush_valid", bus.res_valid_o, 1'b0);
        step();
        check_eq("flush_dropped_tag", bus.res_tag_o, 6'd20);

        // Asynchronous reset while a result is held.
        send(2'd1, 3'd0, '0, '0, 32'h4000, 32'h8, 1'b1, 32'h4008, 6'd30);
        step();
        bus.req_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", bus.res_valid_o, 1'b0);
        check_eq("arst_npc", bus.res_next_pc_o, 32'h0);
        er = '{tag: '0, taken: 1'b0, mis: 1'b0, npc: '0, link: '0, exc: 1'b0};
        ev = 1'b0;
        efresh = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            k   = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pc  = $urandom & 32'hFFFF_FFFC;
            imm = ($urandom_range(0, 1) == 1) ? ($urandom & 32'h0000_0FFE) : $urandom;
            tg  = (k == 2'd2) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
            if ($urandom_range(0, 1) == 0) tg = $urandom;
            send(k, 3'($urandom_range(0, 7)), a, b, pc, imm, 1'($urandom_range(0, 1)), tg,
                 6'($urandom_range(0, 63)));
            bus.req_valid_i = ($urandom_range(0, 4) != 0);
            bus.res_ready_i = ($urandom_range(0, 3) != 0);
            bus.flush_i     = ($urandom_range(0, 19) == 0);
            step();
        end
        bus.req_valid_i = 1'b0;
        bus.flush_i = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
